// File: rtl/ram_access_ctrl_pkg.sv
// Shared types and constants for the breadboard-CPU RAM access controller.
// Optional address-skip tracking is enabled with the RAM_ADDR_SKIP_EN macro.
package bbcpu_ram_pkg;

    localparam int DEF_WIDTH         = 8;
    localparam int DEF_ADDRESS_WIDTH = 4;

    localparam int PORT_CPU = 0;
    localparam int PORT_LDR = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage

// File: rtl/ram_access_ctrl_if.sv
// Requester handshake and RAM strobe/bus signals of the RAM access controller.
interface ram_access_ctrl_if #(
    parameter int WIDTH         = 8,
    parameter int ADDRESS_WIDTH = 4
);
    logic                     req0;
    logic                     req1;
    logic                     we0;
    logic                     we1;
    logic [ADDRESS_WIDTH-1:0] addr0;
    logic [ADDRESS_WIDTH-1:0] addr1;
    logic [WIDTH-1:0]         wdata0;
    logic [WIDTH-1:0]         wdata1;
    logic                     ack0;
    logic                     ack1;
    logic [WIDTH-1:0]         rdata;
    logic                     busy;
    logic                     ram_enable;
    logic                     ram_addr_enable;
    logic                     ram_write_enable;
    logic [WIDTH-1:0]         ram_bus_in;
    logic [WIDTH-1:0]         ram_bus_out;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_bus_out,
        output ack0, ack1, rdata, busy,
        output ram_enable, ram_addr_enable, ram_write_enable, ram_bus_in
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_bus_out,
        input  ack0, ack1, rdata, busy,
        input  ram_enable, ram_addr_enable, ram_write_enable, ram_bus_in
    );
endinterface

// File: rtl/ram_access_ctrl_rr_arbiter2.sv
// Two-requester round-robin arbiter; on a tie the port not granted last wins.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic       valid,
    output logic       grant_idx
);
    logic last_grant;

    always_comb begin
        valid = |req;
        if (req == 2'b11) grant_idx = ~last_grant;
        else              grant_idx = req[1] & ~req[0];
    end

    // Reset value 1 lets port 0 win the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                last_grant <= 1'b1;
        else if (update && valid)  last_grant <= grant_idx;
    end
endmodule

// File: rtl/ram_access_ctrl.sv
// Shares the single-port RAM between two requesters and sequences address-load
// then data cycles; RAM_ADDR_SKIP_EN skips the address load on a repeated address.
module ram_access_ctrl
    import bbcpu_ram_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    ram_access_ctrl_if.slave bus
);
    localparam int PAD = WIDTH - ADDRESS_WIDTH;

    state_t                   state_q, state_d;
    logic                     arb_valid, arb_idx, grant;
    logic                     we_q, port_q;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_sel;
    logic [WIDTH-1:0]         wdata_q, rdata_q;
    logic                     skip_hit;

    logic                     ack0, ack1, busy, ram_en, ram_ae, ram_we;
    logic [WIDTH-1:0]         ram_bus_in;

    rr_arbiter2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       ({bus.req1, bus.req0}),
        .update    (state_q == IDLE),
        .valid     (arb_valid),
        .grant_idx (arb_idx)
    );

    assign grant    = (state_q == IDLE) && arb_valid;
    assign addr_sel = arb_idx ? bus.addr1 : bus.addr0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Requester inputs are only looked at on the grant edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            port_q  <= 1'b0;
        end else if (grant) begin
            we_q    <= arb_idx ? bus.we1 : bus.we0;
            addr_q  <= addr_sel;
            wdata_q <= arb_idx ? bus.wdata1 : bus.wdata0;
            port_q  <= arb_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          rdata_q <= '0;
        else if (state_q == DATA && !we_q)   rdata_q <= bus.ram_bus_out;
    end

`ifdef RAM_ADDR_SKIP_EN
    logic [ADDRESS_WIDTH-1:0] trk_addr_q;
    logic                     trk_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk_addr_q  <= '0;
            trk_valid_q <= 1'b0;
        end else if (state_q == ADDR) begin
            trk_addr_q  <= addr_q;
            trk_valid_q <= 1'b1;
        end
    end

    assign skip_hit = trk_valid_q && (addr_sel == trk_addr_q);
`else
    assign skip_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        ack0       = 1'b0;
        ack1       = 1'b0;
        busy       = 1'b1;
        ram_en     = 1'b0;
        ram_ae     = 1'b0;
        ram_we     = 1'b0;
        ram_bus_in = '0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (arb_valid) state_d = skip_hit ? DATA : ADDR;
            end
            ADDR: begin
                ram_ae     = 1'b1;
                ram_bus_in = {{PAD{1'b0}}, addr_q};
                state_d    = DATA;
            end
            DATA: begin
                if (we_q) begin
                    ram_we     = 1'b1;
                    ram_bus_in = wdata_q;
                end else begin
                    ram_en     = 1'b1;
                end
                state_d = RESP;
            end
            RESP: begin
                if (port_q == 1'(PORT_LDR)) ack1 = 1'b1;
                else                        ack0 = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ack0             = ack0;
    assign bus.ack1             = ack1;
    assign bus.busy             = busy;
    assign bus.rdata            = rdata_q;
    assign bus.ram_enable       = ram_en;
    assign bus.ram_addr_enable  = ram_ae;
    assign bus.ram_write_enable = ram_we;
    assign bus.ram_bus_in       = ram_bus_in;
endmodule

// File: tb/tb_ram_access_ctrl.sv
// Self-checking bench for ram_access_ctrl with a behavioural RAM and a
// transaction-level reference model (define RAM_ADDR_SKIP_EN to test skipping).
module tb_ram_access_ctrl;
`ifdef RAM_ADDR_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ram_access_ctrl_if #(.WIDTH(8), .ADDRESS_WIDTH(4)) bus ();

    ram_access_ctrl #(.WIDTH(8), .ADDRESS_WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural RAM: address register loaded by addr_enable, write at posedge.
    logic [7:0] ram_mem [16];
    logic [3:0] ram_areg;
    always @(posedge clk) begin
        if (bus.ram_addr_enable)  ram_areg <= bus.ram_bus_in[3:0];
        if (bus.ram_write_enable) ram_mem[ram_areg] <= bus.ram_bus_in;
    end
    assign bus.ram_bus_out = bus.ram_enable ? ram_mem[ram_areg] : 8'h00;

    // Reference model state
    logic [7:0] ref_mem [16];
    bit         m_last;
    bit         m_trk_valid;
    logic [3:0] m_trk_addr;
    logic [7:0] m_rdata;

    bit         op_we    [2];
    logic [3:0] op_addr  [2];
    logic [7:0] op_wdata [2];

    int n_total = 0;
    int n_pass  = 0;

    function automatic logic [13:0] obs_vec();
        return {bus.ack0, bus.ack1, bus.busy, bus.ram_addr_enable,
                bus.ram_write_enable, bus.ram_enable, bus.ram_bus_in};
    endfunction

    task automatic model_reset();
        m_last      = 1'b1;
        m_trk_valid = 1'b0;
        m_rdata     = 8'h00;
    endtask

    // Drives the requested ports (from op_*) and checks every cycle until all are served.
    task automatic do_access(input bit r0, input bit r1, input bit mangle);
        logic [1:0]  pending;
        bit          win, skip, g_we;
        logic [3:0]  g_addr;
        logic [7:0]  g_wdata;
        int          ncyc;
        logic [13:0] exp_v, msk;
        bus.req0 = r0; bus.we0 = op_we[0]; bus.addr0 = op_addr[0]; bus.wdata0 = op_wdata[0];
        bus.req1 = r1; bus.we1 = op_we[1]; bus.addr1 = op_addr[1]; bus.wdata1 = op_wdata[1];
        pending = {r1, r0};
        while (pending != 2'b00) begin
            @(posedge clk);
            win     = (pending == 2'b11) ? ~m_last : pending[1];
            m_last  = win;
            g_we    = op_we[win];
            g_addr  = op_addr[win];
            g_wdata = op_wdata[win];
            skip    = SKIP && m_trk_valid && (g_addr == m_trk_addr);
            if (!skip) begin
                m_trk_addr  = g_addr;
                m_trk_valid = 1'b1;
            end
            ncyc = skip ? 2 : 3;
            for (int k = 1; k <= ncyc; k++) begin
                @(negedge clk);
                msk = 14'h3fff;
                if (k == ncyc) begin
                    exp_v = {~win, win, 1'b1, 3'b000, 8'h00};
                    msk   = 14'h3f00;
                end else if (k == ncyc - 1) begin
                    if (g_we) exp_v = {3'b001, 3'b010, g_wdata};
                    else begin
                        exp_v = {3'b001, 3'b001, 8'h00};
                        msk   = 14'h3f00;
                    end
                end else begin
                    exp_v = {3'b001, 3'b100, 4'h0, g_addr};
                end
                n_total++;
                if ((obs_vec() & msk) !== (exp_v & msk))
                    $display("FAIL seq port%0d cyc%0d addr=%0h we=%0d: got %h expected %h (mask %h)",
                             win, k, g_addr, g_we, obs_vec(), exp_v, msk);
                else n_pass++;
                if (k == ncyc) begin
                    if (g_we) ref_mem[g_addr] = g_wdata;
                    else      m_rdata = ref_mem[g_addr];
                    n_total++;
                    if (bus.rdata !== m_rdata)
                        $display("FAIL rdata port%0d addr=%0h: got %h expected %h",
                                 win, g_addr, bus.rdata, m_rdata);
                    else n_pass++;
                    if (win) bus.req1 = 1'b0; else bus.req0 = 1'b0;
                    pending[win] = 1'b0;
                end
                if (mangle && k == 1) begin
                    if (win) begin
                        bus.addr1 = 4'h5; bus.wdata1 = ~g_wdata; bus.req1 = 1'b0;
                    end else begin
                        bus.addr0 = 4'h5; bus.wdata0 = ~g_wdata; bus.req0 = 1'b0;
                    end
                    pending[win] = 1'b0;
                end
            end
            @(posedge clk);
            @(negedge clk);
            n_total++;
            if (obs_vec()[13:8] !== 6'b000000)
                $display("FAIL idle_after_ack: got %b expected 000000", obs_vec()[13:8]);
            else n_pass++;
        end
    endtask

    task automatic set_op(input int p, input bit we, input logic [3:0] a, input logic [7:0] d);
        op_we[p] = we; op_addr[p] = a; op_wdata[p] = d;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        #1;
        n_total++;
        if ({obs_vec(), bus.rdata} !== 22'h0)
            $display("FAIL reset_outputs: got %h expected 0", {obs_vec(), bus.rdata});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
        bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
        for (int i = 0; i < 16; i++) begin
            ram_mem[i] <= 8'(i * 17 + 3);
            ref_mem[i]  = 8'(i * 17 + 3);
        end
        ram_areg <= 4'h0;
        model_reset();
        repeat (3) @(negedge clk);
        n_total++;
        if ({obs_vec(), bus.rdata} !== 22'h0)
            $display("FAIL reset_state: got %h expected 0", {obs_vec(), bus.rdata});
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if ({obs_vec(), bus.rdata} !== 22'h0)
            $display("FAIL idle_after_reset: got %h expected 0", {obs_vec(), bus.rdata});
        else n_pass++;
    endtask

    task automatic test_write_read();
        set_op(0, 1'b1, 4'h3, 8'hA5);
        do_access(1'b1, 1'b0, 1'b0);
        set_op(0, 1'b0, 4'h3, 8'h00);
        do_access(1'b1, 1'b0, 1'b0);
        n_total++;
        if (bus.rdata !== 8'hA5) $display("FAIL read_back_3: got %h expected a5", bus.rdata);
        else n_pass++;
    endtask

    task automatic test_tie();
        set_op(0, 1'b1, 4'h8, 8'h11);
        set_op(1, 1'b1, 4'h9, 8'h22);
        do_access(1'b1, 1'b1, 1'b0);
        set_op(0, 1'b0, 4'h9, 8'h00);
        do_access(1'b1, 1'b0, 1'b0);
        set_op(0, 1'b0, 4'h8, 8'h00);
        set_op(1, 1'b1, 4'h8, 8'h33);
        do_access(1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_change_after_grant();
        set_op(1, 1'b1, 4'h2, 8'h5C);
        do_access(1'b0, 1'b1, 1'b1);
        set_op(1, 1'b0, 4'h2, 8'h00);
        do_access(1'b0, 1'b1, 1'b0);
        set_op(1, 1'b0, 4'h5, 8'h00);
        do_access(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_write();
        bit skip;
        int dcyc;
        set_op(0, 1'b1, 4'hC, 8'hF0);
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 4'hC; bus.wdata0 = 8'hF0;
        @(posedge clk);
        skip = SKIP && m_trk_valid && (m_trk_addr == 4'hC);
        dcyc = skip ? 1 : 2;
        repeat (dcyc) @(negedge clk);
        n_total++;
        if (bus.ram_write_enable !== 1'b1)
            $display("FAIL mid_write_strobe: got %b expected 1", bus.ram_write_enable);
        else n_pass++;
        pulse_reset();
        n_total++;
        if ({bus.ack0, bus.ack1, bus.busy} !== 3'b000)
            $display("FAIL no_ack_after_reset: got %b expected 000", {bus.ack0, bus.ack1, bus.busy});
        else n_pass++;
        set_op(0, 1'b0, 4'hC, 8'h00);
        do_access(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_skip();
        set_op(0, 1'b0, 4'h7, 8'h00);
        do_access(1'b1, 1'b0, 1'b0);
        do_access(1'b1, 1'b0, 1'b0);
        pulse_reset();
        do_access(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int pat;
        for (int i = 0; i < 140; i++) begin
            for (int p = 0; p < 2; p++)
                set_op(p, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom));
            pat = $urandom_range(1, 3);
            do_access(pat[0], pat[1], 1'b0);
        end
        for (int a = 0; a < 16; a++) begin
            n_total++;
            if (ram_mem[a] !== ref_mem[a])
                $display("FAIL final_mem[%0d]: got %h expected %h", a, ram_mem[a], ref_mem[a]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_tie();
        test_change_after_grant();
        test_reset_mid_write();
        test_skip();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
